// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock, then one sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_next;
  logic               is_div_q, sign_a_q, sign_b_q;
  logic [WIDTH-1:0]   m_q;    // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc_q;  // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]      count_q;

  logic               op_signed, op_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shifted;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quot_res, rem_res;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count_q == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand conditioning at accept; -MIN fits unsigned in WIDTH bits.
  always_comb begin
    op_signed = ~op[0];
    op_div    = op[1];
    abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;
  end

  // One iteration of the active algorithm, plus the sign-corrected results used at FIX.
  always_comb begin
    mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : '0)};
    div_shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff    = {1'b0, div_shifted} - {2'b00, m_q};
    if (!is_div_q)
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    else if (!div_diff[WIDTH+1])
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_step = {div_shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    mul_res  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quot_res = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_res  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // NOTE: only architectural state (hi, lo, done) is reset; the working registers are
  // always reloaded on accept, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div_q <= op_div;
            sign_a_q <= op_signed & a[WIDTH-1];
            sign_b_q <= op_signed & b[WIDTH-1];
            m_q      <= op_div ? abs_b : abs_a;
            acc_q    <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
            count_q  <= '0;
          end
        end
        CALC: begin
          acc_q   <= acc_step;
          count_q <= count_q + CW'(1);
        end
        FIX: begin
          if (is_div_q) begin
            hi <= rem_res;
            lo <= quot_res;
          end else begin
            hi <= mul_res[2*WIDTH-1:WIDTH];
            lo <= mul_res[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed boundary cases, randomized ops against an
// arithmetic reference model, handshake/MTHI/MTLO behaviour and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      2'b00: begin q = sa * sb; p = q; end
      2'b01: p = {32'b0, ma} * {32'b0, mb};
      2'b10: begin
        if (mb == 0) p = {ma, (ma[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (mb == 0) p = {ma, 32'hFFFF_FFFF};
        else p = {ma % mb, ma / mb};
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Accept edge happens between the two negedges; returns at the negedge after it.
  task automatic start_op(input logic [1:0] sop, input logic [31:0] sa, input logic [31:0] sb);
    @(negedge clk);
    start = 1'b1; op = sop; a = sa; b = sb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges since accept until done is seen, bounded.
  task automatic wait_done(input int from_edges, output int edges);
    edges = from_edges;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op[8] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [31:0] t_a[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                             32'h8000_0000, 32'd5, 32'd100, 32'hFFFF_FFF9};
    logic [31:0] t_b[8]  = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                             32'hFFFF_FFFF, 32'd0, 32'd7, 32'd0};
    logic [63:0] t_exp[8] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                              64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD,
                              64'h0000_0000_8000_0000, 64'h0000_0005_FFFF_FFFF,
                              64'h0000_0002_0000_000E, 64'hFFFF_FFF9_0000_0001};
    int edges;
    for (int i = 0; i < 8; i++) begin
      start_op(t_op[i], t_a[i], t_b[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_after_accept[%0d]: busy=%b, required 1", i, busy);
      end
      wait_done(0, edges);
      checks++;
      if (edges != 33) begin
        errors++;
        $display("FAIL latency[%0d]: %0d edges, required 33", i, edges);
      end
      checks++;
      if ({hi, lo} !== t_exp[i]) begin
        errors++;
        $display("FAIL directed[%0d]: hi:lo=%h, required %h", i, {hi, lo}, t_exp[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse[%0d]: done=%b busy=%b, required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] exp;
    int edges;
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      exp = model(rop, ra, rb);
      start_op(rop, ra, rb);
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      wait_done(0, edges);
      checks++;
      if (edges != 33 || {hi, lo} !== exp) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: edges=%0d hi:lo=%h, required 33 %h",
                 i, rop, ra, rb, edges, {hi, lo}, exp);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int edges;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_2222;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'h1111_2222 || lo !== 32'h1111_2222) begin
      errors++;
      $display("FAIL mt_both: hi=%h lo=%h, required 11112222 11112222", hi, lo);
    end
    start_op(2'b01, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd1; hi_we = 1'b1; wdata = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checks++;
    if (hi !== 32'h1111_2222 || lo !== 32'h1111_2222) begin
      errors++;
      $display("FAIL no_partial_update: hi=%h lo=%h, required 11112222 11112222", hi, lo);
    end
    wait_done(10, edges);
    checks++;
    if (edges != 33 || hi !== 32'h0 || lo !== 32'd12) begin
      errors++;
      $display("FAIL busy_ignore: edges=%0d hi=%h lo=%h, required 33 0 0000000c", edges, hi, lo);
    end
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'h1234 || hi !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: lo=%h hi=%h busy=%b, required 00001234 0 0", lo, hi, busy);
    end
  endtask

  task automatic test_start_with_mthi();
    int edges;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd5; hi_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checks++;
    if (hi !== 32'hABCD) begin
      errors++;
      $display("FAIL mthi_at_accept: hi=%h, required 0000abcd", hi);
    end
    wait_done(0, edges);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd10) begin
      errors++;
      $display("FAIL mthi_overwritten: hi=%h lo=%h, required 0 0000000a", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, first = 0, second = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    while (second == 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (first == 0) first = n;
        else second = n;
      end
    end
    start = 1'b0;
    checks++;
    if (first != 34 || second - first != 34 || lo !== 32'd81) begin
      errors++;
      $display("FAIL back_to_back: done at %0d,%0d lo=%h, required 34,68 00000051", first, second, lo);
    end
  endtask

  task automatic test_reset_midflight();
    int edges;
    bit seen = 1'b0;
    start_op(2'b10, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_midflight: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL stale_done: done=1 after reset, required 0");
    end
    start_op(2'b00, 32'd2, 32'd3);
    wait_done(0, edges);
    checks++;
    if (edges != 33 || hi !== 32'h0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL after_reset_mult: edges=%0d hi=%h lo=%h, required 33 0 00000006", edges, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_start_with_mthi();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
